// File: rtl/cv32e41s_alert_escalate.sv
// cv32e41s_alert_escalate: security alert collector with windowed minor-to-major escalation
module cv32e41s_alert_escalate #(
    parameter int unsigned MINOR_THRESHOLD = 4,
    parameter int unsigned WINDOW_CYCLES   = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pc_err_i,
    input  logic       rf_ecc_err_i,
    input  logic       csr_err_i,
    input  logic       bus_int_err_i,
    input  logic       lfsr_lockup_i,
    input  logic       sec_exception_i,
    input  logic       esc_en_i,
    output logic       alert_major_o,
    output logic       alert_minor_o,
    output logic       fault_o,
    output logic [4:0] cause_o
);
    localparam int WW = $clog2(WINDOW_CYCLES);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t        state, state_n;
    logic [7:0]    minor_cnt, minor_n, base, next_cnt;
    logic [WW-1:0] win_cnt, win_n;
    logic          major_raw, minor_ev, expire, esc_pulse, major_any;

    assign major_raw = pc_err_i | rf_ecc_err_i | csr_err_i | bus_int_err_i;
    assign minor_ev  = lfsr_lockup_i | sec_exception_i;
    assign major_any = major_raw | esc_pulse;

    always_comb begin
        state_n   = state;
        minor_n   = minor_cnt;
        win_n     = win_cnt;
        esc_pulse = 1'b0;
        expire    = (state == COUNT) && (win_cnt == WW'(WINDOW_CYCLES - 1));
        base      = (state == COUNT && !expire) ? minor_cnt : 8'd0;
        next_cnt  = (base == 8'hff) ? base : base + 8'd1;
        if (!esc_en_i) begin
            state_n = IDLE;
            minor_n = '0;
            win_n   = '0;
        end else if (minor_ev) begin
            if (next_cnt >= 8'(MINOR_THRESHOLD)) begin
                esc_pulse = 1'b1;
                state_n   = IDLE;
                minor_n   = '0;
                win_n     = '0;
            end else begin
                state_n = COUNT;
                minor_n = next_cnt;
                win_n   = (state == IDLE || expire) ? '0 : win_cnt + 1'b1;
            end
        end else if (state == COUNT) begin
            state_n = expire ? IDLE : COUNT;
            minor_n = expire ? '0 : minor_cnt;
            win_n   = expire ? '0 : win_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            minor_cnt <= '0;
            win_cnt   <= '0;
        end else begin
            state     <= state_n;
            minor_cnt <= minor_n;
            win_cnt   <= win_n;
        end
    end

    // cause is captured only on the first major, including every source active then
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alert_major_o <= 1'b0;
            alert_minor_o <= 1'b0;
            fault_o       <= 1'b0;
            cause_o       <= '0;
        end else begin
            alert_major_o <= major_any;
            alert_minor_o <= minor_ev;
            if (!fault_o && major_any) begin
                fault_o <= 1'b1;
                cause_o <= {esc_pulse, bus_int_err_i, csr_err_i, rf_ecc_err_i, pc_err_i};
            end
        end
    end
endmodule

// File: tb/tb_cv32e41s_alert_escalate.sv
// tb_cv32e41s_alert_escalate: directed checks of alert collection, cause capture and escalation
module tb_cv32e41s_alert_escalate;
    logic       clk = 1'b0;
    logic       rst_n, pc, rf, csr, bus, lfsr, sec, esc_en;
    logic       am, an, f, am1, an1, f1;
    logic [4:0] c, c1;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    cv32e41s_alert_escalate dut (
        .clk(clk), .rst_n(rst_n), .pc_err_i(pc), .rf_ecc_err_i(rf), .csr_err_i(csr),
        .bus_int_err_i(bus), .lfsr_lockup_i(lfsr), .sec_exception_i(sec), .esc_en_i(esc_en),
        .alert_major_o(am), .alert_minor_o(an), .fault_o(f), .cause_o(c)
    );

    cv32e41s_alert_escalate #(.MINOR_THRESHOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pc_err_i(pc), .rf_ecc_err_i(rf), .csr_err_i(csr),
        .bus_int_err_i(bus), .lfsr_lockup_i(lfsr), .sec_exception_i(sec), .esc_en_i(esc_en),
        .alert_major_o(am1), .alert_minor_o(an1), .fault_o(f1), .cause_o(c1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {pc, rf, csr, bus, lfsr, sec} = '0;
        esc_en = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if ({am, an, f, c} !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle cycle=%0d got=%b exp=%b", i, {am, an, f, c}, 8'h00);
            end
        end
        checks++;
        if (dut.minor_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_minor_cnt got=%0d exp=0", dut.minor_cnt);
        end
    endtask

    task automatic test_pc_err();
        do_reset();
        pc = 1'b1;
        step();
        pc = 1'b0;
        checks++;
        if ({am, f, c} !== 7'b1_1_00001) begin
            errors++;
            $display("FAIL pc_first got=%b exp=%b", {am, f, c}, 7'b1_1_00001);
        end
        step();
        checks++;
        if ({am, f, c} !== 7'b0_1_00001) begin
            errors++;
            $display("FAIL pc_after got=%b exp=%b", {am, f, c}, 7'b0_1_00001);
        end
    endtask

    task automatic test_multi_cause();
        do_reset();
        csr = 1'b1;
        bus = 1'b1;
        step();
        csr = 1'b0;
        bus = 1'b0;
        checks++;
        if ({am, f, c} !== 7'b1_1_01100) begin
            errors++;
            $display("FAIL multi_first got=%b exp=%b", {am, f, c}, 7'b1_1_01100);
        end
        step();
        checks++;
        if (am !== 1'b0) begin
            errors++;
            $display("FAIL multi_drop got=%b exp=0", am);
        end
        repeat (3) step();
        rf = 1'b1;
        step();
        rf = 1'b0;
        checks++;
        if ({am, f, c} !== 7'b1_1_01100) begin
            errors++;
            $display("FAIL multi_later got=%b exp=%b", {am, f, c}, 7'b1_1_01100);
        end
        step();
        checks++;
        if ({am, c} !== 6'b0_01100) begin
            errors++;
            $display("FAIL multi_hold got=%b exp=%b", {am, c}, 6'b0_01100);
        end
    endtask

    task automatic test_escalate();
        logic ev;
        do_reset();
        for (int i = 0; i <= 30; i++) begin
            ev = (i % 10 == 0);
            lfsr = ev;
            step();
            checks++;
            if ({an, am, am1} !== {ev, i == 30, ev}) begin
                errors++;
                $display("FAIL esc_cycle%0d got=%b exp=%b", i, {an, am, am1}, {ev, i == 30, ev});
            end
        end
        lfsr = 1'b0;
        step();
        checks++;
        if ({am, f, c} !== 7'b0_1_10000) begin
            errors++;
            $display("FAIL esc_cause got=%b exp=%b", {am, f, c}, 7'b0_1_10000);
        end
        checks++;
        if ({f1, c1} !== 6'b1_10000) begin
            errors++;
            $display("FAIL thr1_cause got=%b exp=%b", {f1, c1}, 6'b1_10000);
        end
    endtask

    task automatic test_window();
        logic [7:0] exp_cnt;
        do_reset();
        for (int i = 0; i <= 1100; i++) begin
            lfsr = (i == 0 || i == 400 || i == 800 || i == 1100);
            step();
            checks++;
            if (am !== 1'b0) begin
                errors++;
                $display("FAIL win_major cycle=%0d got=%b exp=0", i, am);
            end
            if (i == 800 || i == 1023 || i == 1024 || i == 1100) begin
                exp_cnt = (i == 1024) ? 8'd0 : (i == 1100) ? 8'd1 : 8'd3;
                checks++;
                if (dut.minor_cnt !== exp_cnt) begin
                    errors++;
                    $display("FAIL win_cnt cycle=%0d got=%0d exp=%0d", i, dut.minor_cnt, exp_cnt);
                end
            end
        end
        lfsr = 1'b0;
        checks++;
        if (f !== 1'b0) begin
            errors++;
            $display("FAIL win_fault got=%b exp=0", f);
        end
    endtask

    task automatic test_expiry_event();
        do_reset();
        for (int i = 0; i <= 1024; i++) begin
            lfsr = (i < 3 || i == 1024);
            step();
        end
        lfsr = 1'b0;
        checks++;
        if ({am, dut.minor_cnt, dut.win_cnt} !== {1'b0, 8'd1, 10'd0}) begin
            errors++;
            $display("FAIL expiry_event got=%b/%0d/%0d exp=0/1/0", am, dut.minor_cnt, dut.win_cnt);
        end
    endtask

    task automatic test_esc_disabled();
        do_reset();
        esc_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            lfsr = i[0];
            sec  = ~i[0];
            step();
            checks++;
            if ({an, am, f, am1, dut.minor_cnt} !== {4'b1000, 8'd0}) begin
                errors++;
                $display("FAIL esc_off cycle=%0d got=%b exp=%b", i, {an, am, f, am1, dut.minor_cnt}, {4'b1000, 8'd0});
            end
        end
        {lfsr, sec} = 2'b00;
        step();
        checks++;
        if ({an, f} !== 2'b00) begin
            errors++;
            $display("FAIL esc_off_end got=%b exp=00", {an, f});
        end
        esc_en = 1'b1;
    endtask

    task automatic test_major_and_esc();
        do_reset();
        for (int i = 0; i <= 30; i++) begin
            lfsr = (i % 10 == 0);
            sec  = (i == 10);
            pc   = (i == 30);
            step();
            if (i == 20) begin
                checks++;
                if (dut.minor_cnt !== 8'd3) begin
                    errors++;
                    $display("FAIL both_src_cnt got=%0d exp=3", dut.minor_cnt);
                end
            end
        end
        {lfsr, sec, pc} = 3'b000;
        checks++;
        if ({am, c} !== 6'b1_10001) begin
            errors++;
            $display("FAIL maj_esc got=%b exp=%b", {am, c}, 6'b1_10001);
        end
        step();
        checks++;
        if (am !== 1'b0) begin
            errors++;
            $display("FAIL maj_esc_single got=%b exp=0", am);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            lfsr = (i == 0 || i == 2 || i == 4);
            pc   = (i == 1);
            step();
        end
        lfsr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({am, an, f, c, dut.minor_cnt, dut.win_cnt} !== '0) begin
            errors++;
            $display("FAIL async_clear got=%b/%0d/%0d exp=0/0/0", {am, an, f, c}, dut.minor_cnt, dut.win_cnt);
        end
        #1 rst_n = 1'b1;
        step();
        lfsr = 1'b1;
        step();
        lfsr = 1'b0;
        checks++;
        if ({an, am, f, dut.minor_cnt} !== {3'b100, 8'd1}) begin
            errors++;
            $display("FAIL async_restart got=%b/%0d exp=100/1", {an, am, f}, dut.minor_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_pc_err();
        test_multi_cause();
        test_escalate();
        test_window();
        test_expiry_event();
        test_esc_disabled();
        test_major_and_esc();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
